// File: rtl/mc_alu_pkg.sv
// mc_alu_pkg: opcode constants, FSM state type and opcode classification helper
// shared by mc_alu and mc_alu_comb.
package mc_alu_pkg;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_SLTU = 4'b1111;
    localparam logic [3:0] CTL_NOR  = 4'b1100;
    localparam logic [3:0] CTL_SLL  = 4'b1000;
    localparam logic [3:0] CTL_SRL  = 4'b1001;
    localparam logic [3:0] CTL_SRA  = 4'b1010;
    localparam logic [3:0] CTL_MUL  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] ctl);
        return (ctl == CTL_SLL) || (ctl == CTL_SRL) || (ctl == CTL_SRA);
    endfunction

endpackage

// File: rtl/mc_alu_comb.sv
// mc_alu_comb: single-cycle ALU functions (logic, add/sub, set-less-than) with
// signed overflow; o_single flags whether i_ctl is one of these operations.
module mc_alu_comb
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_ctl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_ovf,
    output logic             o_single
);

    logic signed [WIDTH-1:0] w_as;
    logic signed [WIDTH-1:0] w_bs;
    logic        [WIDTH-1:0] w_sum;
    logic        [WIDTH-1:0] w_diff;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    assign w_as   = i_a;
    assign w_bs   = i_b;
    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_y      = '0;
        o_ovf    = 1'b0;
        o_single = 1'b1;
        case (i_ctl)
            CTL_AND:  o_y = i_a & i_b;
            CTL_OR:   o_y = i_a | i_b;
            CTL_NOR:  o_y = ~(i_a | i_b);
            CTL_ADD: begin
                o_y   = w_sum;
                o_ovf = add_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_sum[WIDTH-1]);
            end
            CTL_SUB: begin
                o_y   = w_diff;
                o_ovf = sub_ovf(i_a[WIDTH-1], i_b[WIDTH-1], w_diff[WIDTH-1]);
            end
            CTL_SLT:  o_y = {{(WIDTH-1){1'b0}}, (w_as < w_bs)};
            CTL_SLTU: o_y = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            default:  o_single = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with valid/ready handshake; 1-bit-per-cycle shifter and,
// when MC_ALU_MUL_EN is defined, a shift-add multiplier (otherwise MUL is illegal).
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_ctl;
    logic [WIDTH-1:0]   r_opa;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               r_err;

    logic [WIDTH-1:0]   w_y;
    logic               w_ovf;
    logic               w_single;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic               w_start_iter;
    logic               w_last;
    logic [WIDTH-1:0]   w_sh_next;

`ifdef MC_ALU_MUL_EN
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     w_psum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_is_mul;

    assign w_is_mul     = (ctl == CTL_MUL);
    // High half accumulates the multiplicand, then the whole product shifts right.
    assign w_psum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_opb[0] ? r_opa : '0)};
    assign w_prod_next  = {w_psum, r_prod[WIDTH-1:1]};
    assign w_start_iter = (w_is_shift && (w_shamt != '0)) || w_is_mul;
`else
    assign w_start_iter = w_is_shift && (w_shamt != '0);
`endif

    mc_alu_comb #(.WIDTH(WIDTH)) u_comb (
        .i_ctl    (ctl),
        .i_a      (a),
        .i_b      (b),
        .o_y      (w_y),
        .o_ovf    (w_ovf),
        .o_single (w_single)
    );

    assign w_shamt    = b[SHAMT_W-1:0];
    assign w_is_shift = is_shift(ctl);
    assign w_last     = (r_cnt == CNT_W'(1));

    always_comb begin
        case (r_ctl)
            CTL_SLL: w_sh_next = r_opa << 1;
            CTL_SRL: w_sh_next = r_opa >> 1;
            default: w_sh_next = {r_opa[WIDTH-1], r_opa[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = w_start_iter ? S_ITER : S_DONE;
            end
            S_ITER: if (w_last) w_state_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctl    <= '0;
            r_opa    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
`ifdef MC_ALU_MUL_EN
            r_opb    <= '0;
            r_prod   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_ctl <= ctl;
                    if (w_single) begin
                        r_result <= w_y;
                        r_zero   <= (w_y == '0);
                        r_ovf    <= w_ovf;
                        r_err    <= 1'b0;
                    end else if (w_is_shift) begin
                        if (w_shamt == '0) begin
                            r_result <= a;
                            r_zero   <= (a == '0);
                            r_ovf    <= 1'b0;
                            r_err    <= 1'b0;
                        end else begin
                            r_opa <= a;
                            r_cnt <= {1'b0, w_shamt};
                        end
                    end
`ifdef MC_ALU_MUL_EN
                    else if (w_is_mul) begin
                        r_opa  <= a;
                        r_opb  <= b;
                        r_prod <= '0;
                        r_cnt  <= CNT_W'(WIDTH);
                    end
`endif
                    else begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b1;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt - 1'b1;
`ifdef MC_ALU_MUL_EN
                    if (r_ctl == CTL_MUL) begin
                        r_prod <= w_prod_next;
                        r_opb  <= r_opb >> 1;
                        if (w_last) begin
                            r_result <= w_prod_next[WIDTH-1:0];
                            r_zero   <= (w_prod_next[WIDTH-1:0] == '0);
                            r_ovf    <= |w_prod_next[2*WIDTH-1:WIDTH];
                            r_err    <= 1'b0;
                        end
                    end else
`endif
                    begin
                        r_opa <= w_sh_next;
                        if (w_last) begin
                            r_result <= w_sh_next;
                            r_zero   <= (w_sh_next == '0);
                            r_ovf    <= 1'b0;
                            r_err    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign ovf    = r_ovf;
    assign err    = r_err;

endmodule

// File: tb/tb_mc_alu.sv
// Testbench for mc_alu: directed vector table, reset/back-pressure sequences and
// randomized ops checked against an arithmetic reference model.
module tb_mc_alu;

    localparam int W = 32;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ctl = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         err;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          z;
        bit          o;
        bit          e;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        bit          z;
        bit          o;
        bit          e;
        int          lat;
    } exp_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctl       (ctl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        exp_t        t;
        longint      s;
        logic [63:0] p;
        int          k;
        t.r = '0; t.o = 1'b0; t.e = 1'b0; t.lat = 1;
        k = int'(y[4:0]);
        p = '0;
        case (c)
            OP_AND:  t.r = x & y;
            OP_OR:   t.r = x | y;
            OP_NOR:  t.r = ~(x | y);
            OP_ADD: begin
                s = longint'($signed(x)) + longint'($signed(y));
                t.r = s[31:0];
                t.o = (s != longint'($signed(t.r)));
            end
            OP_SUB: begin
                s = longint'($signed(x)) - longint'($signed(y));
                t.r = s[31:0];
                t.o = (s != longint'($signed(t.r)));
            end
            OP_SLT:  t.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU: t.r = (x < y) ? 32'd1 : 32'd0;
            OP_SLL: begin t.r = x << k; t.lat = (k == 0) ? 1 : k + 1; end
            OP_SRL: begin t.r = x >> k; t.lat = (k == 0) ? 1 : k + 1; end
            OP_SRA: begin t.r = 32'($signed(x) >>> k); t.lat = (k == 0) ? 1 : k + 1; end
`ifdef MC_ALU_MUL_EN
            OP_MUL: begin
                p = {32'b0, x} * {32'b0, y};
                t.r = p[31:0];
                t.o = (p[63:32] != 0);
                t.lat = 33;
            end
`endif
            default: t.e = 1'b1;
        endcase
        t.z = (t.r == 0);
        return t;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after the transfer.
    task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output bit z, output bit o, output bit e,
                          output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_issue", in_ready, 1);
        ctl = c; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            ctl = 4'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
            lat++;
        end
        r = result; z = zero; o = ovf; e = err;
        @(negedge clk);
        chk("out_valid_drop_after_transfer", out_valid, 0);
        chk("in_ready_after_transfer", in_ready, 1);
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] r, input bit z, input bit o, input bit e,
                                input int lat);
        vec_t v;
        v.c = c; v.a = x; v.b = y; v.r = r; v.z = z; v.o = o; v.e = e; v.lat = lat;
        return v;
    endfunction

    initial begin
        logic [31:0] r;
        bit          z, o, e;
        int          lat;
        int          seen;
        exp_t        ex;
        logic [3:0]  c;
        logic [31:0] x, y;

        vecs.push_back(mk(OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 1));
        vecs.push_back(mk(OP_SUB,  32'h5,        32'h5,        32'h0,        1, 0, 0, 1));
        vecs.push_back(mk(OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 1));
        vecs.push_back(mk(OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 1));
        vecs.push_back(mk(4'b0011, 32'h123,      32'h456,      32'h0,        1, 0, 1, 1));
        vecs.push_back(mk(OP_SRA,  32'h80000000, 32'h4,        32'hF8000000, 0, 0, 0, 5));
        vecs.push_back(mk(OP_SLL,  32'hDEADBEEF, 32'h20,       32'hDEADBEEF, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, 0, 1));
        vecs.push_back(mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1));
        vecs.push_back(mk(OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SRL,  32'h80000000, 32'h1F,       32'h1,        0, 0, 0, 32));
        vecs.push_back(mk(OP_SLL,  32'h1,        32'h1F,       32'h80000000, 0, 0, 0, 32));
        vecs.push_back(mk(OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 1));
        vecs.push_back(mk(OP_SRA,  32'h40000000, 32'h3,        32'h08000000, 0, 0, 0, 4));
`ifdef MC_ALU_MUL_EN
        vecs.push_back(mk(OP_MUL,  32'h10000,    32'h10000,    32'h0,        1, 1, 0, 33));
        vecs.push_back(mk(OP_MUL,  32'h7,        32'h6,        32'd42,       0, 0, 0, 33));
`else
        vecs.push_back(mk(OP_MUL,  32'h10000,    32'h10000,    32'h0,        1, 0, 1, 1));
        vecs.push_back(mk(OP_MUL,  32'h7,        32'h6,        32'h0,        1, 0, 1, 1));
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {zero, ovf, err}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].c, vecs[i].a, vecs[i].b, r, z, o, e, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].r);
            chk($sformatf("vec%0d_zero", i), z, vecs[i].z);
            chk($sformatf("vec%0d_ovf", i), o, vecs[i].o);
            chk($sformatf("vec%0d_err", i), e, vecs[i].e);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Reset in the middle of a long operation
        run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, r, z, o, e, lat);
`ifdef MC_ALU_MUL_EN
        ctl = OP_MUL; a = 32'h12345; b = 32'h6789;
`else
        ctl = OP_SRL; a = 32'hFFFFFFFF; b = 32'd20;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midop_reset_out_valid", out_valid, 0);
        chk("midop_reset_in_ready", in_ready, 1);
        chk("midop_reset_result", result, 0);
        chk("midop_reset_flags", {zero, ovf, err}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midop_post_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midop_no_stale_result", seen, 0);

        // Back-pressure: result held, in_valid pulses ignored
        out_ready = 1'b0;
        ctl = OP_SUB; a = 32'h80000000; b = 32'h1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_out_valid_rise", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; ctl = OP_ADD; a = $urandom; b = $urandom;
            @(negedge clk);
            chk("bp_hold_out_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_result", result, 32'h7FFFFFFF);
            chk("bp_hold_flags", {zero, ovf, err}, 3'b010);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("bp_ignored_pulses", seen, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 200; i++) begin
            c = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 3))
                0: x = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'h7FFFFFFF} ^ 32'($urandom_range(0, 1));
                1: y = 32'($urandom_range(0, 3));
                default: ;
            endcase
            ex = model(c, x, y);
            run_op(c, x, y, r, z, o, e, lat);
            chk($sformatf("rand%0d_ctl%0h_result", i, c), r, ex.r);
            chk($sformatf("rand%0d_ctl%0h_flags", i, c), {z, o, e}, {ex.z, ex.o, ex.e});
            chk($sformatf("rand%0d_ctl%0h_latency", i, c), lat, ex.lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
